// File: rtl/ff_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ff_pkg : shared definitions for the field-arithmetic issue controller.
//   FF_W        default operand/result width
//   FF_AW       register index width
//   FF_NREGS    number of architectural registers
//   FF_TIMEOUT  default WAIT-cycle budget before an operation is aborted
//   FF_LAT_W    width of the latency counter / last_lat output
//   ff_state_e  controller FSM encoding
//   sat_inc     saturating increment used by the WAIT-cycle counter
// -----------------------------------------------------------------------------
package ff_pkg;

    localparam int FF_W       = 256;
    localparam int FF_AW      = 3;
    localparam int FF_NREGS   = 8;
    localparam int FF_TIMEOUT = 1024;
    localparam int FF_LAT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } ff_state_e;

    // Saturating increment: the counter never wraps back to zero, so a
    // runaway WAIT can never alias onto the "first cycle" blanking slot.
    function automatic logic [FF_LAT_W-1:0] sat_inc(input logic [FF_LAT_W-1:0] v);
        logic [FF_LAT_W-1:0] r;
        if (v == {FF_LAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(FF_LAT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/ff_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// ff_issue_ctrl_if : command handshake plus unit handshake of the controller.
//   cmd_valid/cmd_ready  command handshake (ready driven by the controller)
//   cmd_load             1 = immediate load, 0 = unit operation
//   cmd_dst/srca/srcb    register indices
//   cmd_imm              immediate data
//   u_start              one-cycle start pulse to the arithmetic unit
//   u_a/u_b              operands, stable for the whole operation
//   u_out/u_done         unit result and completion
// Modports: master = environment (command source + unit), slave = controller.
// -----------------------------------------------------------------------------
interface ff_issue_ctrl_if
    import ff_pkg::*;
#(
    parameter int W = FF_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [FF_AW-1:0] cmd_dst;
    logic [FF_AW-1:0] cmd_srca;
    logic [FF_AW-1:0] cmd_srcb;
    logic [W-1:0]     cmd_imm;
    logic             u_start;
    logic [W-1:0]     u_a;
    logic [W-1:0]     u_b;
    logic [W-1:0]     u_out;
    logic             u_done;

    modport master (
        output cmd_valid, cmd_load, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
        output u_out, u_done,
        input  cmd_ready, u_start, u_a, u_b
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
        input  u_out, u_done,
        output cmd_ready, u_start, u_a, u_b
    );

endinterface

// File: rtl/ff_issue_ctrl_regfile.sv
// -----------------------------------------------------------------------------
// ff_regfile : 8 x W register file.
//   clk, rst          clock, synchronous active-low clear of every entry
//   we/waddr/wdata    single synchronous write port
//   raddr_a/rdata_a   asynchronous read port (operand A)
//   raddr_b/rdata_b   asynchronous read port (operand B)
//   raddr_c/rdata_c   asynchronous read port (readback)
// -----------------------------------------------------------------------------
module ff_regfile
    import ff_pkg::*;
#(
    parameter int W = FF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [FF_AW-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [FF_AW-1:0] raddr_a,
    output logic [W-1:0]     rdata_a,
    input  logic [FF_AW-1:0] raddr_b,
    output logic [W-1:0]     rdata_b,
    input  logic [FF_AW-1:0] raddr_c,
    output logic [W-1:0]     rdata_c
);

    logic [W-1:0] mem_q [FF_NREGS];

    // Storage: clear all entries in reset, otherwise apply the write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FF_NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end else begin
            mem_q[waddr] <= mem_q[waddr];
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];
    assign rdata_c = mem_q[raddr_c];

endmodule

// File: rtl/ff_issue_ctrl.sv
// -----------------------------------------------------------------------------
// ff_issue_ctrl : issues register-file operands to a multi-cycle field
// arithmetic unit and writes the result back.
//   clk       clock
//   rst       synchronous active-low reset
//   bus       ff_issue_ctrl_if.slave (command + unit handshakes)
//   rd_addr   readback register index
//   rd_data   asynchronous readback data
//   busy      high whenever the FSM is outside IDLE
//   last_lat  number of WAIT cycles of the last completed operation
//   err       sticky timeout flag, cleared only by reset
// Loads complete in IDLE on the accept edge. Operations go
// IDLE -> ISSUE -> WAIT -> WRITE -> IDLE, or WAIT -> IDLE on timeout.
// -----------------------------------------------------------------------------
module ff_issue_ctrl
    import ff_pkg::*;
#(
    parameter int W       = FF_W,
    parameter int TIMEOUT = FF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    ff_issue_ctrl_if.slave      bus,
    input  logic [FF_AW-1:0]    rd_addr,
    output logic [W-1:0]        rd_data,
    output logic                busy,
    output logic [FF_LAT_W-1:0] last_lat,
    output logic                err
);

    // Counter value in the last permitted WAIT cycle (counter is 0 in cycle 1).
    localparam logic [FF_LAT_W-1:0] WAIT_LAST = FF_LAT_W'(TIMEOUT - 1);

    ff_state_e            state_q, state_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic [W-1:0]         res_q, res_d;
    logic [FF_AW-1:0]     dst_q, dst_d;
    logic [FF_LAT_W-1:0]  cnt_q, cnt_d;
    logic [FF_LAT_W-1:0]  lat_q, lat_d;
    logic [FF_LAT_W-1:0]  last_lat_q, last_lat_d;
    logic                 err_q, err_d;

    logic                 cmd_ready_s;
    logic                 accept_s;
    logic                 done_ok_s;
    logic                 timeout_s;
    logic                 u_start_s;
    logic                 busy_s;
    logic                 rf_we_s;
    logic [FF_AW-1:0]     rf_waddr_s;
    logic [W-1:0]         rf_wdata_s;
    logic [W-1:0]         rf_a_s;
    logic [W-1:0]         rf_b_s;

    // Ready is forced low while reset is asserted, even before the first edge.
    assign cmd_ready_s = (state_q == ST_IDLE) && rst;
    assign accept_s    = bus.cmd_valid && cmd_ready_s;

    // The first WAIT cycle (counter 0) is blanked so a level-done left over
    // from the previous operation cannot complete this one.
    assign done_ok_s = (state_q == ST_WAIT) && (cnt_q != '0) && bus.u_done;
    assign timeout_s = (state_q == ST_WAIT) && !done_ok_s && (cnt_q >= WAIT_LAST);

    ff_regfile #(
        .W (W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_a (bus.cmd_srca),
        .rdata_a (rf_a_s),
        .raddr_b (bus.cmd_srcb),
        .rdata_b (rf_b_s),
        .raddr_c (rd_addr),
        .rdata_c (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !bus.cmd_load) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_ok_s) begin
                    state_d = ST_WRITE;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode.
    always_comb begin
        u_start_s = 1'b0;
        busy_s    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_ISSUE: begin
                u_start_s = 1'b1;
            end
            ST_WAIT: begin
                u_start_s = 1'b0;
            end
            ST_WRITE: begin
                u_start_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand latch, WAIT counting, result capture.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        dst_d      = dst_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                // Operands are read at accept, so dst==src is safe.
                if (accept_s && !bus.cmd_load) begin
                    a_d   = rf_a_s;
                    b_d   = rf_b_s;
                    dst_d = bus.cmd_dst;
                end else begin
                    a_d = a_q;
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                cnt_d = sat_inc(cnt_q);
                if (done_ok_s) begin
                    res_d = bus.u_out;
                    lat_d = sat_inc(cnt_q);
                end else if (timeout_s) begin
                    err_d = 1'b1;
                end else begin
                    res_d = res_q;
                end
            end
            ST_WRITE: begin
                last_lat_d = lat_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Register-file write port: loads in IDLE, results in WRITE, never both.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = bus.cmd_dst;
        rf_wdata_s = bus.cmd_imm;
        if (state_q == ST_WRITE) begin
            rf_we_s    = 1'b1;
            rf_waddr_s = dst_q;
            rf_wdata_s = res_q;
        end else if (accept_s && bus.cmd_load) begin
            rf_we_s = 1'b1;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            dst_q      <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            last_lat_q <= '0;
            err_q      <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            dst_q      <= dst_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.u_start   = u_start_s;
    assign bus.u_a       = a_q;
    assign bus.u_b       = b_q;
    assign busy          = busy_s;
    assign last_lat      = last_lat_q;
    assign err           = err_q;

endmodule
